booth_div: RTL

//  Sequential signed integer divider; the inverse datapath of the Booth multiplier.

---
 rtl/booth_div.sv | 88 ++++++++
 1 files changed

// File: rtl/booth_div.sv
// booth_div: sequential signed restoring divider with truncating quotient/remainder and dbz/ovf flags
module booth_div #(
  parameter int DW = 15,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);
  localparam int CW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
  state_t state, state_n;
  logic [DW-1:0] a, dq;
  logic [VW-1:0] b;
  logic [VW:0] rem, dv, sh, nx;
  logic [CW-1:0] cnt;
  logic ge, is_dbz, is_ovf, q_neg;
  // rem[VW] is always clear in practice; folding it into ge keeps the compare exact for the full shifted value
  assign sh = {rem[VW-1:0], dq[DW-1]};
  assign nx = sh - dv;
  assign ge = rem[VW] | (sh >= dv);
  assign is_dbz = b == '0;
  assign is_ovf = a == {1'b1, {(DW-1){1'b0}}} && b == '1;
  assign q_neg = a[DW-1] ^ b[VW-1];
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state: divide-by-zero skips the iteration phase
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? PREP : IDLE) :
              state == PREP ? (is_dbz ? FIX : CALC) :
              state == CALC ? (cnt == CW'(DW-1) ? FIX : CALC) : IDLE;
  end
  // datapath: capture, magnitude prep, one quotient bit per cycle, sign fix-up
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a <= '0;
      b <= '0;
      dq <= '0;
      rem <= '0;
      dv <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      dbz <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a <= dividend;
          b <= divisor;
          busy <= 1'b1;
        end
        PREP: begin
          dq <= a[DW-1] ? -a : a;
          dv <= b[VW-1] ? -{1'b1, b} : {1'b0, b};
          rem <= '0;
          cnt <= '0;
        end
        CALC: begin
          rem <= ge ? nx : sh;
          dq <= {dq[DW-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        default: begin
          done <= 1'b1;
          busy <= 1'b0;
          dbz <= is_dbz;
          ovf <= is_ovf;
          quotient <= is_dbz ? '0 : is_ovf ? {1'b0, {(DW-1){1'b1}}} : q_neg ? -dq : dq;
          remainder <= is_dbz || is_ovf ? '0 : a[DW-1] ? -rem[VW-1:0] : rem[VW-1:0];
        end
      endcase
    end
endmodule
